// File: rtl/int_to_fp32.sv
// Iterative 32-bit int (signed/unsigned) to IEEE-754 single converter; start/done handshake, one normalize shift per cycle.
// Latency 4+k cycles (k = leading zeros of magnitude), 3 for zero; start ignored while busy. Define I2F_RNE_EN for round-to-nearest-even.
module int_to_fp32 #(
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_val,
    input  logic        is_signed,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);
    localparam logic [7:0] EXP_SEED = 8'(EXP_BIAS + 31);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ABS  = 2'd1,
        NORM = 2'd2,
        PACK = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic [31:0] r_result;
    logic        r_done;
    logic [22:0] w_frac;
    logic [7:0]  w_exp_out;
    logic [31:0] w_packed;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ABS;
            ABS:     w_next = (r_mag == 32'd0) ? PACK : NORM;
            NORM:    if (r_mag[31]) w_next = PACK;
            PACK:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

`ifdef I2F_RNE_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_lsb;
    logic        w_inc;
    logic [23:0] w_frac_sum;

    assign w_guard    = r_mag[7];
    assign w_sticky   = |r_mag[6:0];
    assign w_lsb      = r_mag[8];
    assign w_inc      = w_guard & (w_sticky | w_lsb);
    // A carry out of the fraction leaves the low 23 bits at zero and bumps the exponent.
    assign w_frac_sum = {1'b0, r_mag[30:8]} + {23'd0, w_inc};
    assign w_frac     = w_frac_sum[22:0];
    assign w_exp_out  = r_exp + {7'd0, w_frac_sum[23]};
`else
    assign w_frac     = r_mag[30:8];
    assign w_exp_out  = r_exp;
`endif

    assign w_packed = (r_mag == 32'd0) ? 32'd0 : {r_sign, w_exp_out, w_frac};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_mag    <= 32'd0;
            r_exp    <= 8'd0;
            r_result <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == PACK);
            case (r_state)
                IDLE: begin
                    // Raw operand parks in mag/sign until ABS resolves the signedness.
                    if (start) begin
                        r_mag  <= in_val;
                        r_sign <= is_signed;
                    end
                end
                ABS: begin
                    if (r_sign && r_mag[31]) r_mag <= -r_mag;
                    r_sign <= r_sign & r_mag[31];
                    r_exp  <= EXP_SEED;
                end
                NORM: begin
                    if (!r_mag[31]) begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                PACK:    r_result <= w_packed;
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_int_to_fp32.sv
// Randomized and directed bench for int_to_fp32, checked against an arithmetic reference model.
module tb_int_to_fp32;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in_val;
    logic        is_signed;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    int_to_fp32 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_val    (in_val),
        .is_signed (is_signed),
        .result    (result),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference: locate the leading one arithmetically, divide down to 24 significant bits.
    function automatic logic [31:0] ref_fp(input logic [31:0] v, input logic s);
        logic neg;
        longint unsigned m, frac, rem, half;
        int p, e;
        neg = s && v[31];
        m = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        if (m == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
        e = 127 + p;
        if (p <= 23) begin
            frac = (m << (23 - p)) - (64'd1 << 23);
            rem  = 0;
            half = 1;
        end else begin
            frac = (m >> (p - 23)) - (64'd1 << 23);
            rem  = m % (64'd1 << (p - 23));
            half = 64'd1 << (p - 24);
        end
`ifdef I2F_RNE_EN
        if (rem > half || (rem == half && frac % 2 == 1)) frac = frac + 1;
        if (frac == (64'd1 << 23)) begin
            frac = 0;
            e = e + 1;
        end
`endif
        return {neg, e[7:0], frac[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] v, input logic s);
        longint unsigned m;
        int p;
        m = (s && v[31]) ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        if (m == 0) return 2;
        p = 0;
        for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
        return 3 + (31 - p);
    endfunction

    // Called at a negedge with the DUT idle (or showing done). lat = edges after the sampling edge until done.
    task automatic run_conv(input logic [31:0] v, input logic s, input bit poke,
                            input logic [31:0] poke_val, output int lat, output logic [31:0] res);
        in_val    = v;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        in_val    = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        check_eq("done_low_after_start", {31'd0, done}, 32'd0);
        lat = 0;
        while (!done && lat < 100) begin
            if (poke && lat == 3) begin
                start  = 1'b1;
                in_val = poke_val;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
        end
        res = result;
    endtask

    task automatic conv_and_check(input string tag, input logic [31:0] v, input logic s);
        int lat;
        logic [31:0] res;
        run_conv(v, s, 1'b0, 32'd0, lat, res);
        check_eq({tag, "_res"}, res, ref_fp(v, s));
        check_eq({tag, "_lat"}, 32'(lat), 32'(ref_lat(v, s)));
        check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] v;
        logic        s;
        logic [31:0] exp_trunc;
        logic [31:0] exp_rne;
    } vec_t;

    vec_t dir[8];

    initial begin
        int lat, done_cnt;
        logic [31:0] res, v;
        logic s;

        dir[0] = '{32'h0000_0001, 1'b0, 32'h3F80_0000, 32'h3F80_0000};
        dir[1] = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 32'hBF80_0000};
        dir[2] = '{32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 32'h4F80_0000};
        dir[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000};
        dir[4] = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 32'hCF00_0000};
        dir[5] = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 32'h4F00_0000};
        dir[6] = '{32'h0100_0003, 1'b0, 32'h4B80_0001, 32'h4B80_0002};
        dir[7] = '{32'h0100_0001, 1'b0, 32'h4B80_0000, 32'h4B80_0000};

        reset = 1'b1; start = 1'b0; in_val = 32'd0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (dir[i]) begin
            run_conv(dir[i].v, dir[i].s, 1'b0, 32'd0, lat, res);
`ifdef I2F_RNE_EN
            check_eq($sformatf("dir%0d_const", i), res, dir[i].exp_rne);
`else
            check_eq($sformatf("dir%0d_const", i), res, dir[i].exp_trunc);
`endif
            check_eq($sformatf("dir%0d_model", i), res, ref_fp(dir[i].v, dir[i].s));
            check_eq($sformatf("dir%0d_lat", i), 32'(lat), 32'(ref_lat(dir[i].v, dir[i].s)));
            @(negedge clk);
        end

        // Result holds while idle.
        repeat (4) @(negedge clk);
        check_eq("hold", result, ref_fp(dir[7].v, dir[7].s));

        // Randomized operands with varied magnitude widths, issued back-to-back on the done cycle.
        for (int i = 0; i < 40; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) v = -v;
            if ($urandom_range(0, 15) == 0) v = 32'd0;
            s = 1'($urandom_range(0, 1));
            conv_and_check($sformatf("rnd%0d", i), v, s);
        end

        // Start re-pulsed while busy must be ignored.
        @(negedge clk);
        run_conv(32'h0000_1234, 1'b0, 1'b1, 32'h7654_3210, lat, res);
        check_eq("busy_poke_res", res, ref_fp(32'h0000_1234, 1'b0));
        check_eq("busy_poke_lat", 32'(lat), 32'(ref_lat(32'h0000_1234, 1'b0)));
        // Immediately restart on the done cycle.
        conv_and_check("on_done", 32'hFFFF_8001, 1'b1);

        // Reset during NORM aborts with no done pulse.
        @(negedge clk);
        in_val = 32'd1; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_result", result, 32'd0);
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        conv_and_check("after_abort", 32'hFFFF_FF85, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
